// File: rtl/accl_sched.sv
// Pair scheduler: walks body memory, issues every (i,j) pair into getAccl and tags results.
// Optional macro ACCL_SCHED_SKIP_SELF_EN drops the j == i read/issue.
module accl_sched #(
  parameter int N_MAX    = 1024,
  parameter int IDX_W    = 10,
  parameter int PIPE_LAT = 123
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   n_bodies,
  output logic             busy,
  output logic             done,
  output logic             mem_rd,
  output logic [IDX_W-1:0] mem_addr,
  input  logic [63:0]      mem_x,
  input  logic [63:0]      mem_y,
  input  logic [63:0]      mem_m,
  output logic [63:0]      pipe_x1,
  output logic [63:0]      pipe_y1,
  output logic [63:0]      pipe_x2,
  output logic [63:0]      pipe_y2,
  output logic [63:0]      pipe_m2,
  input  logic [63:0]      pipe_ax,
  input  logic [63:0]      pipe_ay,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_first,
  output logic             res_last,
  output logic [63:0]      res_ax,
  output logic [63:0]      res_ay
);
  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, LOAD_I, RUN_J, DRAIN} state_t;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             first;
    logic             last;
  } tag_t;

  state_t state, state_nx;
  logic [CW-1:0] n_r, i_r, k_r, runs, j_cur;
  logic          run_d, first_d, last_d, ld_d, zero_done;
  logic [IDX_W-1:0] i_d;
  logic          k_last, i_last, in_flight, go;
  logic [PIPE_LAT-1:0] vld_pipe;
  tag_t [PIPE_LAT-1:0] tag_pipe;
  tag_t          tag_in;

  // k_r counts RUN_J cycles for body i; j_cur maps it to the body actually read.
`ifdef ACCL_SCHED_SKIP_SELF_EN
  assign runs  = n_r - ONE;
  assign j_cur = (k_r >= i_r) ? k_r + ONE : k_r;
`else
  assign runs  = n_r;
  assign j_cur = k_r;
`endif

  assign k_last    = (k_r == runs - ONE);
  assign i_last    = (i_r + ONE >= n_r);
  assign in_flight = run_d | (|vld_pipe);
  assign go        = start && (n_bodies != '0);

  assign pipe_x2   = mem_x;
  assign pipe_y2   = mem_y;
  assign pipe_m2   = mem_m;
  assign res_ax    = pipe_ax;
  assign res_ay    = pipe_ay;
  assign res_valid = vld_pipe[PIPE_LAT-1];
  assign res_idx   = tag_pipe[PIPE_LAT-1].idx;
  assign res_first = tag_pipe[PIPE_LAT-1].first;
  assign res_last  = tag_pipe[PIPE_LAT-1].last;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    mem_addr = '0;
    done     = zero_done;
    case (state)
      IDLE:   if (go) state_nx = LOAD_I;
      LOAD_I: begin
        mem_rd   = 1'b1;
        mem_addr = i_r[IDX_W-1:0];
        // only reachable with self-skip and a single body
        if (runs == '0) state_nx = i_last ? DRAIN : LOAD_I;
        else            state_nx = RUN_J;
      end
      RUN_J: begin
        mem_rd   = 1'b1;
        mem_addr = j_cur[IDX_W-1:0];
        if (k_last) state_nx = i_last ? DRAIN : LOAD_I;
      end
      DRAIN: if (!in_flight) begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tag_in = '0;
    if (run_d) tag_in = '{idx: i_d, first: first_d, last: last_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r       <= '0;
      i_r       <= '0;
      k_r       <= '0;
      run_d     <= 1'b0;
      i_d       <= '0;
      first_d   <= 1'b0;
      last_d    <= 1'b0;
      ld_d      <= 1'b0;
      zero_done <= 1'b0;
      pipe_x1   <= '0;
      pipe_y1   <= '0;
      vld_pipe  <= '0;
      tag_pipe  <= '0;
    end else begin
      zero_done <= (state == IDLE) && start && (n_bodies == '0);
      run_d     <= (state == RUN_J);
      i_d       <= i_r[IDX_W-1:0];
      first_d   <= (k_r == '0);
      last_d    <= k_last;
      ld_d      <= (state == LOAD_I);
      // body i arrives the cycle after LOAD_I; the last pair of i-1 issues with the old value
      if (ld_d) begin
        pipe_x1 <= mem_x;
        pipe_y1 <= mem_y;
      end
      case (state)
        IDLE: if (go) begin
          n_r <= (n_bodies > CW'(N_MAX)) ? CW'(N_MAX) : n_bodies;
          i_r <= '0;
          k_r <= '0;
        end
        LOAD_I: begin
          k_r <= '0;
          if (runs == '0) i_r <= i_r + ONE;
        end
        RUN_J: begin
          if (k_last) begin
            k_r <= '0;
            i_r <= i_r + ONE;
          end else begin
            k_r <= k_r + ONE;
          end
        end
        default: ;
      endcase
      vld_pipe <= {vld_pipe[PIPE_LAT-2:0], run_d};
      tag_pipe <= {tag_pipe[PIPE_LAT-2:0], tag_in};
    end
  end
endmodule

// File: tb/tb_accl_sched.sv
// Directed bench for accl_sched with a behavioural getAccl stand-in and body memory.
module tb_accl_sched;
  localparam int IDX_W = 10;
  localparam int L     = 123;
`ifdef ACCL_SCHED_SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [IDX_W:0] n_bodies = '0;
  logic busy, done, mem_rd, res_valid, res_first, res_last;
  logic [IDX_W-1:0] mem_addr, res_idx;
  logic [63:0] mem_x = '0, mem_y = '0, mem_m = '0;
  logic [63:0] pipe_x1, pipe_y1, pipe_x2, pipe_y2, pipe_m2, pipe_ax, pipe_ay, res_ax, res_ay;

  accl_sched #(.N_MAX(1024), .IDX_W(IDX_W), .PIPE_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .n_bodies(n_bodies), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y), .mem_m(mem_m),
    .pipe_x1(pipe_x1), .pipe_y1(pipe_y1), .pipe_x2(pipe_x2), .pipe_y2(pipe_y2),
    .pipe_m2(pipe_m2), .pipe_ax(pipe_ax), .pipe_ay(pipe_ay), .res_valid(res_valid),
    .res_idx(res_idx), .res_first(res_first), .res_last(res_last),
    .res_ax(res_ax), .res_ay(res_ay));

  always #5 clk = ~clk;

  // body memory, one-cycle read latency
  logic [63:0] mx [1024], my [1024], mm [1024];
  always @(posedge clk) if (mem_rd) begin
    mem_x <= mx[mem_addr];
    mem_y <= my[mem_addr];
    mem_m <= mm[mem_addr];
  end

  // getAccl stand-in: fixed latency L, self pairs (r == 0) give zero
  function automatic real acc(input real d, input real dx, input real dy, input real m);
    real r2;
    r2 = dx * dx + dy * dy;
    if (r2 == 0.0) return 0.0;
    return m * d / (r2 * $sqrt(r2));
  endfunction
  logic [63:0] axp [L], ayp [L];
  real dxm, dym, m2m;
  always @(posedge clk) begin
    dxm = $bitstoreal(pipe_x2) - $bitstoreal(pipe_x1);
    dym = $bitstoreal(pipe_y2) - $bitstoreal(pipe_y1);
    m2m = $bitstoreal(pipe_m2);
    axp[0] <= $realtobits(acc(dxm, dxm, dym, m2m));
    ayp[0] <= $realtobits(acc(dym, dxm, dym, m2m));
    for (int s = 1; s < L; s++) begin
      axp[s] <= axp[s-1];
      ayp[s] <= ayp[s-1];
    end
  end
  assign pipe_ax = axp[L-1];
  assign pipe_ay = ayp[L-1];

  // monitor: everything logged with cycle numbers relative to the start cycle
  typedef struct {int cyc; int idx; bit f; bit l; logic [63:0] ax; logic [63:0] ay;} res_t;
  int cyc = 0, base = 0, rel, busy_n = 0;
  res_t rq[$], rtmp;
  int dq[$], rd_cyc[$], rd_addr[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rel = cyc - base;
    if (mem_rd) begin rd_cyc.push_back(rel); rd_addr.push_back(int'(mem_addr)); end
    if (busy) busy_n = busy_n + 1;
    if (done) dq.push_back(rel);
    if (res_valid) begin
      rtmp.cyc = rel; rtmp.idx = int'(res_idx); rtmp.f = res_first; rtmp.l = res_last;
      rtmp.ax = res_ax; rtmp.ay = res_ay;
      rq.push_back(rtmp);
    end
  end

  int errs = 0, checks = 0;
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_r(input string tag, input real obs, input real exp);
    bit ok;
    ok = ((obs - exp) < 1e-9) && ((exp - obs) < 1e-9);
    checks++;
    assert (ok === 1'b1) else begin
      errs++;
      $error("FAIL %s: got %f expected %f", tag, obs, exp);
    end
  endtask

  int rq0, dq0, bq0, rd0;
  task automatic snap();
    rq0 = rq.size(); dq0 = dq.size(); bq0 = busy_n; rd0 = rd_cyc.size();
  endtask
  task automatic do_start(input int n);
    @(negedge clk); #2;
    snap();
    start = 1'b1; n_bodies = (IDX_W+1)'(n); base = cyc;
    @(negedge clk); #2;
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    int w;
    w = 0;
    while (dq.size() == dq0 && w < budget) begin @(negedge clk); w++; end
    repeat (6) @(negedge clk);
  endtask

  real ref_ax [3][3], ref_ay [3][3];

  // expected (i,j) order, tags and cycles for an n-body pass
  task automatic check_pass(input int n, input bit vals, input string nm);
    int ei[$], ej[$], ec[$];
    bit ef[$], el[$];
    int runs, k, got, dc;
    runs = SKIP ? n - 1 : n;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        if (SKIP && i == j) continue;
        k = (SKIP && j > i) ? j - 1 : j;
        ei.push_back(i); ej.push_back(j); ef.push_back(k == 0); el.push_back(k == runs - 1);
        ec.push_back(SKIP ? 3 + i*n + k + L : 3 + i*(n+1) + j + L);
      end
    got = rq.size() - rq0;
    chk({nm, ".res_count"}, got, ei.size());
    for (int e = 0; e < ei.size() && e < got; e++) begin
      chk($sformatf("%s.r%0d.cyc", nm, e), rq[rq0+e].cyc, ec[e]);
      chk($sformatf("%s.r%0d.idx", nm, e), rq[rq0+e].idx, ei[e]);
      chk($sformatf("%s.r%0d.first", nm, e), rq[rq0+e].f, ef[e]);
      chk($sformatf("%s.r%0d.last", nm, e), rq[rq0+e].l, el[e]);
      if (vals) begin
        chk_r($sformatf("%s.r%0d.ax", nm, e), $bitstoreal(rq[rq0+e].ax), ref_ax[ei[e]][ej[e]]);
        chk_r($sformatf("%s.r%0d.ay", nm, e), $bitstoreal(rq[rq0+e].ay), ref_ay[ei[e]][ej[e]]);
      end
    end
    dc = SKIP ? n*n + 2 + L : n*n + n + 2 + L;
    chk({nm, ".done_count"}, dq.size() - dq0, 1);
    if (dq.size() > dq0) chk({nm, ".done_cyc"}, dq[dq0], dc);
    chk({nm, ".busy_cycles"}, busy_n - bq0, dc);
  endtask

  task automatic check_n2(input string nm);
    int ec[$], ea[$];
    if (SKIP) begin ec = '{1, 2, 3, 4}; ea = '{0, 1, 1, 0}; end
    else begin ec = '{1, 2, 3, 4, 5, 6}; ea = '{0, 0, 1, 1, 0, 1}; end
    chk({nm, ".rd_count"}, rd_cyc.size() - rd0, ec.size());
    for (int e = 0; e < ec.size() && rd0 + e < rd_cyc.size(); e++) begin
      chk($sformatf("%s.rd%0d.cyc", nm, e), rd_cyc[rd0+e], ec[e]);
      chk($sformatf("%s.rd%0d.addr", nm, e), rd_addr[rd0+e], ea[e]);
    end
    check_pass(2, 1'b0, nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  real s5;
  initial begin
    for (int a = 0; a < 1024; a++) begin
      mx[a] = $realtobits(real'(a) * 3.0); my[a] = $realtobits(real'(a) + 7.0);
      mm[a] = $realtobits(1.0);
    end
    // bodies (0,0) m=1, (1,0) m=2, (0,2) m=4
    mx[0] = $realtobits(0.0); my[0] = $realtobits(0.0); mm[0] = $realtobits(1.0);
    mx[1] = $realtobits(1.0); my[1] = $realtobits(0.0); mm[1] = $realtobits(2.0);
    mx[2] = $realtobits(0.0); my[2] = $realtobits(2.0); mm[2] = $realtobits(4.0);
    s5 = 5.0 * $sqrt(5.0);
    ref_ax[0] = '{0.0, 2.0, 0.0};         ref_ay[0] = '{0.0, 0.0, 1.0};
    ref_ax[1] = '{-1.0, 0.0, -4.0 / s5};  ref_ay[1] = '{0.0, 0.0, 8.0 / s5};
    ref_ax[2] = '{0.0, 2.0 / s5, 0.0};    ref_ay[2] = '{-0.25, -4.0 / s5, 0.0};

    // reset held
    repeat (3) @(negedge clk);
    chk("rst.ctrl", {busy, done, mem_rd, res_valid, res_first, res_last}, 0);
    chk("rst.addr", {mem_addr, res_idx}, 0);
    chk("rst.x1", pipe_x1, 0);
    chk("rst.y1", pipe_y1, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle.busy", busy, 0);

    // n = 0: immediate done, no reads, never busy
    do_start(0);
    repeat (5) @(negedge clk);
    chk("n0.done_count", dq.size() - dq0, 1);
    if (dq.size() > dq0) chk("n0.done_cyc", dq[dq0], 1);
    chk("n0.rd_count", rd_cyc.size() - rd0, 0);
    chk("n0.busy", busy_n - bq0, 0);

    do_start(2);
    wait_done(400);
    check_n2("n2");

    do_start(3);
    wait_done(400);
    check_pass(3, 1'b1, "n3");

    // start re-pulsed mid-pass is ignored
    do_start(4);
    repeat (10) @(negedge clk);
    #2 start = 1'b1; n_bodies = 7;
    @(negedge clk); #2 start = 1'b0;
    wait_done(400);
    check_pass(4, 1'b0, "n4");

    // reset in DRAIN discards in-flight tags
    do_start(5);
    repeat (60) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    snap();
    repeat (200) @(negedge clk);
    chk("rst5.res_count", rq.size() - rq0, 0);
    chk("rst5.done_count", dq.size() - dq0, 0);
    chk("rst5.busy", busy_n - bq0, 0);

    do_start(2);
    wait_done(400);
    check_n2("n2b");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
